// File: rtl/regbank_arb_pkg.sv
// Shared definitions for the regbank access arbiter: default widths and FSM state encoding.
package regbank_arb_pkg;

  localparam int AW_DEF          = 7;
  localparam int DW_DEF          = 8;
  localparam int SYNC_STAGES_DEF = 2;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_I2C_WR   = 2'd1,
    ST_HOST_ACC = 2'd2,
    ST_HOST_GNT = 2'd3
  } state_e;

endpackage

// File: rtl/regbank_arb_sync_edge.sv
// Multi-flop synchronizer with a rising-edge pulse that is armed only once the
// synchronized input has been observed low after reset.
module sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] fill_q;
  logic                   prev_q;
  logic                   armed_q;
  logic                   synced;
  logic                   filled;

  assign synced = sync_q[SYNC_STAGES-1];
  // The reset zeros in the chain are not real samples; arming waits until
  // the chain holds only post-reset values of din.
  assign filled = fill_q[SYNC_STAGES-1];

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour; blocking here would collapse the chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      fill_q  <= '0;
      prev_q  <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], din};
      fill_q  <= {fill_q[SYNC_STAGES-2:0], 1'b1};
      prev_q  <= synced;
      armed_q <= armed_q | (filled & ~synced);
    end
  end

  assign rise = armed_q & synced & ~prev_q;

endmodule

// File: rtl/regbank_arb.sv
// Arbitrates the regbank port between a non-stallable I2C write strobe and a host
// req/gnt handshake. Optional I2C write protection: define REGBANK_ARB_WPROT_EN.
module regbank_arb
  import regbank_arb_pkg::*;
#(
  parameter int            AW          = AW_DEF,
  parameter int            DW          = DW_DEF,
  parameter int            SYNC_STAGES = SYNC_STAGES_DEF,
  parameter logic [AW-1:0] WPROT_BASE  = AW'('h70)
) (
  input  logic          clk_50M,
  input  logic          rst_n,
  input  logic          i2c_store,
  input  logic [AW-1:0] i2c_addr,
  input  logic [DW-1:0] i2c_wrdata,
  output logic [DW-1:0] i2c_rddata,
  input  logic          host_req,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_wrdata,
  output logic          host_gnt,
  output logic [DW-1:0] host_rddata,
  output logic [AW-1:0] rb_addr,
  output logic [DW-1:0] rb_wrdata,
  output logic          rb_we,
  input  logic [DW-1:0] rb_rddata,
  input  logic          ovf_clr,
  output logic          ovf,
  output logic          wprot_err
);

`ifdef REGBANK_ARB_WPROT_EN
  localparam bit WPROT_ON = 1'b1;
`else
  localparam bit WPROT_ON = 1'b0;
`endif

  state_e        state_q, state_d;
  logic          i2c_rise;
  logic          pend_q;
  logic [AW-1:0] lat_addr_q;
  logic [DW-1:0] lat_data_q;
  logic          ovf_q;
  logic          wprot_hit;

  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_store_edge (
    .clk   (clk_50M),
    .rst_n (rst_n),
    .din   (i2c_store),
    .rise  (i2c_rise)
  );

  assign wprot_hit = WPROT_ON && (lat_addr_q >= WPROT_BASE);

  // NOTE: every output of this block gets a default before the case so no
  // path leaves a signal unassigned, which would infer a latch.
  always_comb begin
    state_d   = state_q;
    rb_addr   = '0;
    rb_wrdata = '0;
    rb_we     = 1'b0;
    host_gnt  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        rb_addr = i2c_addr;
        if (pend_q)        state_d = ST_I2C_WR;
        else if (host_req) state_d = ST_HOST_ACC;
      end
      ST_I2C_WR: begin
        rb_addr = lat_addr_q;
        if (!wprot_hit) begin
          rb_we     = 1'b1;
          rb_wrdata = lat_data_q;
        end
        state_d = host_req ? ST_HOST_ACC : ST_IDLE;
      end
      ST_HOST_ACC: begin
        rb_addr   = host_addr;
        rb_we     = host_we;
        rb_wrdata = host_we ? host_wrdata : '0;
        state_d   = ST_HOST_GNT;
      end
      ST_HOST_GNT: begin
        host_gnt = 1'b1;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      pend_q      <= 1'b0;
      lat_addr_q  <= '0;
      lat_data_q  <= '0;
      ovf_q       <= 1'b0;
      i2c_rddata  <= '0;
      host_rddata <= '0;
    end else begin
      state_q <= state_d;
      // A strobe landing during I2C_WR re-arms pend: the write being issued
      // uses the old latch contents, so nothing is lost.
      if (i2c_rise) begin
        pend_q     <= 1'b1;
        lat_addr_q <= i2c_addr;
        lat_data_q <= i2c_wrdata;
      end else if (state_q == ST_I2C_WR) begin
        pend_q <= 1'b0;
      end
      if (i2c_rise && pend_q && state_q != ST_I2C_WR) ovf_q <= 1'b1;
      else if (ovf_clr)                               ovf_q <= 1'b0;
      if (state_q == ST_IDLE) i2c_rddata <= rb_rddata;
      if (state_q == ST_HOST_ACC && !host_we) host_rddata <= rb_rddata;
    end
  end

  assign ovf = ovf_q;

`ifdef REGBANK_ARB_WPROT_EN
  logic wprot_err_q;

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n)                                wprot_err_q <= 1'b0;
    else if (state_q == ST_I2C_WR && wprot_hit) wprot_err_q <= 1'b1;
  end

  assign wprot_err = wprot_err_q;
`else
  assign wprot_err = 1'b0;
`endif

endmodule
